// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
interface if_fetch_stage_if #(
  parameter int AW = 64,
  parameter int IW = 32
);
  logic          IMemReq;
  logic [AW-1:0] IMemAddr;
  logic          IMemAck;
  logic [IW-1:0] IMemData;

  // Fetch stage side: issues requests, consumes returned words.
  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemAck,
    input  IMemData
  );

  // Memory side: observes requests, returns words.
  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemAck,
    output IMemData
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the request/ack handshake with
// instruction memory, loads the IF/ID register, and handles stall and branch
// redirect. A one-word skid buffer parks a word that arrives while stalled so
// it is neither lost nor refetched.
module if_fetch_stage #(
  parameter int            AW       = 64,
  parameter int            IW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [AW-1:0]         PCOut,
  input  logic [AW-1:0]         PCPlus4,
  input  logic                  BranchTaken,
  input  logic [AW-1:0]         BranchTarget,
  input  logic                  Stall,
  if_fetch_stage_if.master      imem,
  output logic [AW-1:0]         IFID_PC,
  output logic [IW-1:0]         IFID_Instr,
  output logic                  IFID_Valid
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t        r_state, w_state;
  logic [AW-1:0] r_pc, w_pc;
  logic [IW-1:0] r_skid, w_skid;
  logic [AW-1:0] r_ifid_pc, w_ifid_pc;
  logic [IW-1:0] r_ifid_instr, w_ifid_instr;
  logic          r_ifid_valid, w_ifid_valid;

  logic          w_ack;
  logic [AW-1:0] w_tgt_aligned;

  // Only an ack that answers a live request counts; the target is word aligned.
  assign w_ack         = imem.IMemAck & (r_state == S_REQ);
  assign w_tgt_aligned = BranchTarget & ~{{(AW-2){1'b0}}, 2'b11};

  assign imem.IMemReq  = (r_state == S_REQ) & ~RESET;
  assign imem.IMemAddr = r_pc;
  assign PCOut         = r_pc;
  assign IFID_PC       = r_ifid_pc;
  assign IFID_Instr    = r_ifid_instr;
  assign IFID_Valid    = r_ifid_valid;

  // Next-state and next-register values; branch outranks stall, stall outranks ack.
  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_skid       = r_skid;
    w_ifid_pc    = r_ifid_pc;
    w_ifid_instr = r_ifid_instr;
    w_ifid_valid = r_ifid_valid;

    if (BranchTaken) begin
      // Redirect drops both the skid word and any ack arriving this cycle.
      w_pc         = w_tgt_aligned;
      w_ifid_valid = 1'b0;
      w_state      = S_REQ;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (w_ack && !Stall) begin
            w_ifid_pc    = r_pc;
            w_ifid_instr = imem.IMemData;
            w_ifid_valid = 1'b1;
            w_pc         = PCPlus4;
          end else if (w_ack && Stall) begin
            // Word arrived but IF/ID is frozen: park it and stop requesting.
            w_skid  = imem.IMemData;
            w_state = S_HOLD;
          end else if (!Stall) begin
            w_ifid_valid = 1'b0;
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            w_ifid_pc    = r_pc;
            w_ifid_instr = r_skid;
            w_ifid_valid = 1'b1;
            w_pc         = PCPlus4;
            w_state      = S_REQ;
          end
        end
        default: w_state = S_REQ;
      endcase
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_skid       <= '0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_skid       <= w_skid;
      r_ifid_pc    <= w_ifid_pc;
      r_ifid_instr <= w_ifid_instr;
      r_ifid_valid <= w_ifid_valid;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table, hand-written corner
// sequences, then randomized stimulus against a behavioural model.
module tb_if_fetch_stage;

  localparam int AW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_plus4;
  logic          br;
  logic [AW-1:0] tgt;
  logic          stall;
  logic [AW-1:0] ifid_pc;
  logic [IW-1:0] ifid_instr;
  logic          ifid_valid;

  int checks = 0;
  int errors = 0;

  if_fetch_stage_if #(.AW(AW), .IW(IW)) u_bus ();

  if_fetch_stage #(.AW(AW), .IW(IW), .RESET_PC(64'h0)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .PCOut        (pc_out),
    .PCPlus4      (pc_plus4),
    .BranchTaken  (br),
    .BranchTarget (tgt),
    .Stall        (stall),
    .imem         (u_bus.master),
    .IFID_PC      (ifid_pc),
    .IFID_Instr   (ifid_instr),
    .IFID_Valid   (ifid_valid)
  );

  always #5 clk = ~clk;

  // PC-tagged instruction word stored at address a.
  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000 ^ {a[63:48], 16'h0};
  endfunction

  // External adder and memory: data is only meaningful when acked.
  assign pc_plus4       = pc_out + 64'd4;
  assign u_bus.IMemData = u_bus.IMemAck ? word(u_bus.IMemAddr) : ~word(u_bus.IMemAddr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic b, input logic [63:0] t,
                       input logic s, input logic a);
    rst = r; br = b; tgt = t; stall = s; u_bus.IMemAck = a;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [63:0] e_pc, input logic e_v,
                            input logic [63:0] e_ifpc, input logic [31:0] e_instr,
                            input logic e_req);
    chk({tag, ".pc"},    pc_out,               e_pc);
    chk({tag, ".valid"}, {63'b0, ifid_valid},  {63'b0, e_v});
    chk({tag, ".ifpc"},  ifid_pc,              e_ifpc);
    chk({tag, ".instr"}, {32'b0, ifid_instr},  {32'b0, e_instr});
    chk({tag, ".req"},   {63'b0, u_bus.IMemReq}, {63'b0, e_req});
    chk({tag, ".addr"},  u_bus.IMemAddr,       e_pc);
  endtask

  typedef struct {
    logic        rst, br;
    logic [63:0] tgt;
    logic        stall, ack;
    logic [63:0] e_pc;
    logic        e_v;
    logic [63:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_req;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic b, input logic [63:0] t,
                              input logic s, input logic a, input logic [63:0] epc,
                              input logic ev, input logic [63:0] eifpc,
                              input logic [31:0] einstr, input logic ereq);
    vec_t v;
    v.rst = r; v.br = b; v.tgt = t; v.stall = s; v.ack = a;
    v.e_pc = epc; v.e_v = ev; v.e_ifpc = eifpc; v.e_instr = einstr; v.e_req = ereq;
    return v;
  endfunction

  // Behavioural model: PC, IF/ID contents and whether a fetched word is parked.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr;
  logic        m_valid, m_parked;

  task automatic model_step(input logic r, input logic b, input logic [63:0] t,
                            input logic s, input logic a);
    if (r) begin
      m_pc = 64'h0; m_parked = 1'b0; m_ifpc = 64'h0; m_instr = 32'h0; m_valid = 1'b0;
    end else if (b) begin
      m_pc = {t[63:2], 2'b00}; m_valid = 1'b0; m_parked = 1'b0;
    end else if (m_parked) begin
      if (!s) begin
        m_ifpc = m_pc; m_instr = word(m_pc); m_valid = 1'b1;
        m_pc = m_pc + 64'd4; m_parked = 1'b0;
      end
    end else if (a && !s) begin
      m_ifpc = m_pc; m_instr = word(m_pc); m_valid = 1'b1; m_pc = m_pc + 64'd4;
    end else if (a && s) begin
      m_parked = 1'b1;
    end else if (!s) begin
      m_valid = 1'b0;
    end
  endtask

  vec_t tbl[18];

  initial begin
    rst = 1'b1; br = 1'b0; tgt = '0; stall = 1'b0; u_bus.IMemAck = 1'b0;

    tbl[0]  = mk(1,0,0,    0,0, 64'h0,   0, 64'h0,  32'h0,        0);
    tbl[1]  = mk(0,0,0,    0,1, 64'h4,   1, 64'h0,  word(64'h0),  1);
    tbl[2]  = mk(0,0,0,    0,1, 64'h8,   1, 64'h4,  word(64'h4),  1);
    tbl[3]  = mk(0,0,0,    1,1, 64'h8,   1, 64'h4,  word(64'h4),  0);
    tbl[4]  = mk(0,0,0,    1,1, 64'h8,   1, 64'h4,  word(64'h4),  0);
    tbl[5]  = mk(0,0,0,    1,0, 64'h8,   1, 64'h4,  word(64'h4),  0);
    tbl[6]  = mk(0,0,0,    0,0, 64'hC,   1, 64'h8,  word(64'h8),  1);
    tbl[7]  = mk(0,0,0,    0,1, 64'h10,  1, 64'hC,  word(64'hC),  1);
    tbl[8]  = mk(0,0,0,    0,0, 64'h10,  0, 64'hC,  word(64'hC),  1);
    tbl[9]  = mk(0,0,0,    0,0, 64'h10,  0, 64'hC,  word(64'hC),  1);
    tbl[10] = mk(0,0,0,    0,1, 64'h14,  1, 64'h10, word(64'h10), 1);
    tbl[11] = mk(0,0,0,    0,0, 64'h14,  0, 64'h10, word(64'h10), 1);
    tbl[12] = mk(0,0,0,    0,0, 64'h14,  0, 64'h10, word(64'h10), 1);
    tbl[13] = mk(0,0,0,    0,1, 64'h18,  1, 64'h14, word(64'h14), 1);
    tbl[14] = mk(0,0,0,    0,1, 64'h1C,  1, 64'h18, word(64'h18), 1);
    tbl[15] = mk(0,0,0,    0,1, 64'h20,  1, 64'h1C, word(64'h1C), 1);
    tbl[16] = mk(0,1,64'h103,0,1, 64'h100, 0, 64'h1C, word(64'h1C), 1);
    tbl[17] = mk(0,0,0,    0,1, 64'h104, 1, 64'h100,word(64'h100),1);

    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].rst, tbl[i].br, tbl[i].tgt, tbl[i].stall, tbl[i].ack);
      expect_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_v, tbl[i].e_ifpc,
                 tbl[i].e_instr, tbl[i].e_req);
    end

    // Branch while holding a parked word: the parked word must not surface.
    apply(0,0,0,1,1);
    expect_all("hold104", 64'h104, 1, 64'h100, word(64'h100), 0);
    apply(0,1,64'h40,1,0);
    expect_all("brhold", 64'h40, 0, 64'h100, word(64'h100), 1);
    apply(0,0,0,0,1);
    expect_all("after_brhold", 64'h44, 1, 64'h40, word(64'h40), 1);

    // Reset while holding a parked word.
    apply(0,0,0,1,1);
    expect_all("hold44", 64'h44, 1, 64'h40, word(64'h40), 0);
    apply(1,0,0,1,1);
    expect_all("rsthold", 64'h0, 0, 64'h0, 32'h0, 0);
    apply(0,0,0,0,1);
    expect_all("after_rsthold", 64'h4, 1, 64'h0, word(64'h0), 1);

    // PC wrap through the external adder.
    apply(0,1,64'hFFFF_FFFF_FFFF_FFFE,0,0);
    expect_all("br_top", 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, word(64'h0), 1);
    apply(0,0,0,0,1);
    expect_all("wrap", 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, word(64'hFFFF_FFFF_FFFF_FFFC), 1);

    // Randomized run against the model.
    model_step(1,0,0,0,0);
    apply(1,0,0,0,0);
    expect_all("rnd_rst", m_pc, m_valid, m_ifpc, m_instr, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      logic        r, b, s, a;
      logic [63:0] t;
      r = ($urandom_range(0, 99) == 0);
      b = ($urandom_range(0, 15) == 0);
      t = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                      : {32'($urandom), 32'($urandom)};
      s = ($urandom_range(0, 2) == 0);
      a = $urandom_range(0, 1) == 1;
      model_step(r, b, t, s, a);
      apply(r, b, t, s, a);
      expect_all($sformatf("rnd%0d", n), m_pc, m_valid, m_ifpc, m_instr, ~m_parked & ~r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined ARMv8 core.
- Owns the program counter and drives PCOut into the PC+4 adder (ADDER4.B). Consumes the adder result (ADDER4.Out) as the sequential next PC.
- Runs a request/ack handshake with instruction memory and loads the IF/ID pipeline register.
- Supports hazard-unit stall and branch redirect with flush.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset (must be 4-byte aligned)
AW, 64, address/PC width
IW, 32, instruction width

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
PCOut  output  AW  current PC register; drives ADDER4.B
PCPlus4  input  AW  ADDER4.Out (combinational PCOut+4)
BranchTaken  input  1  redirect request from EX/MEM
BranchTarget  input  AW  redirect address; bits [1:0] forced to 0 on load
Stall  input  1  hazard unit: hold IF/ID and PC
IMemReq  output  1  fetch request
IMemAddr  output  AW  fetch address, always equals PCOut
IMemAck  input  1  memory returns IMemData for IMemAddr this cycle
IMemData  input  IW  instruction word, valid when IMemAck=1
IFID_PC  output  AW  PC of instruction in IF/ID
IFID_Instr  output  IW  instruction in IF/ID
IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset is synchronous and active-high on CLK: PCOut=RESET_PC, state=S_REQ, skid=0, IFID_PC=0, IFID_Instr=0, IFID_Valid=0.
- IMemReq = (state==S_REQ) & ~RESET (combinational). IMemAddr = PCOut.
- Memory contract: IMemAck is qualified against the address presented in the same cycle. IMemReq may be withdrawn or IMemAddr changed without penalty. Ack while IMemReq=0 is ignored.
- Priority per edge: RESET > BranchTaken > Stall > ack/normal.
- BranchTaken=1 in any state:
  - PCOut <= {BranchTarget[AW-1:2],2'b00}.
  - IFID_Valid <= 0; IFID_PC/IFID_Instr hold.
  - state <= S_REQ.
  - An IMemAck in the same cycle is dropped.
- State S_REQ (request outstanding):
  - Ack=1, Stall=0: IFID_PC<=PCOut, IFID_Instr<=IMemData, IFID_Valid<=1, PCOut<=PCPlus4. Stay S_REQ. Back-to-back acks give one instruction per cycle.
  - Ack=1, Stall=1: skid<=IMemData, PCOut holds, IF/ID holds, state<=S_HOLD.
  - Ack=0, Stall=0: IFID_Valid<=0 (bubble); PCOut holds.
  - Ack=0, Stall=1: IF/ID and PCOut hold.
- State S_HOLD (fetched word parked in skid, IMemReq=0):
  - Stall=1: everything holds.
  - Stall=0: IFID_PC<=PCOut, IFID_Instr<=skid, IFID_Valid<=1, PCOut<=PCPlus4, state<=S_REQ.
- Latency:
  - Zero-wait memory: an instruction at PC p appears in IF/ID one edge after its ack cycle.
  - Fetch-to-fetch throughput is 1/cycle.
  - A redirect costs at least 1 bubble.
- Arithmetic:
  - No addition inside this block; next sequential PC comes only from PCPlus4.
  - Wrap at 2^AW is whatever ADDER4 produces (0xFFFF_FFFF_FFFF_FFFC -> 0).
- No instruction is lost or duplicated across any Stall/ack combination. The only exception is a branch, which discards the skid and the in-flight fetch.
- RESET asserted mid-operation (any state, pending skid) takes effect at that edge; the skid content is discarded.

Test Plan:
- Reset, then IMemAck tied 1, Stall=0, IMemData=PC-tagged words -> PCOut 0,4,8,12 on consecutive cycles; IFID_PC trails PCOut by one cycle with matching Instr; IFID_Valid=1 from the 2nd edge.
- Ack=1 with Stall=1 at PC=8 for 3 cycles -> state S_HOLD, IMemReq=0, PCOut=8, IF/ID frozen. After Stall drops: IFID_PC=8, Instr=word@8, then fetch resumes at 12.
- Memory with 2 wait states per fetch (ack every 3rd cycle) -> IFID_Valid pattern 1,0,0 repeating; PCOut advances only on ack cycles.
- BranchTaken=1, BranchTarget=0x103 in the same cycle as Ack=1 at PC=0x20 -> PCOut=0x100, IFID_Valid=0, ack data dropped; the next ack delivers IFID_PC=0x100.
- In S_HOLD with Stall=1, assert BranchTaken (target 0x40) -> skid discarded, state S_REQ, PCOut=0x40. Separately, RESET in S_HOLD -> PCOut=RESET_PC, IFID_Valid=0.
- PCOut driven to 0xFFFF_FFFF_FFFF_FFFC via branch, then one ack -> PCOut=0 (adder wrap), IFID_PC=0xFFFF_FFFF_FFFF_FFFC.
